// File: rtl/branch_cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_cond_unit: ALU flag register, branch condition evaluation and   |
// | one-deep taken/target buffer with valid/ack handshake.   Rev 1.0       |
// +------------------------------------------------------------------------+
module branch_cond_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              sign_in,
  input  logic              ovf_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_op,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              rs_zero,
  input  logic              rs_neg,
  output logic              take_valid,
  output logic              take,
  output logic [ADDR_W-1:0] take_target,
  input  logic              take_ack,
  output logic [3:0]        flags_q,
  output logic              illegal_op
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  logic [3:0]          r_flags;
  logic                r_take;
  logic [ADDR_W-1:0]   r_take_target;
  logic                r_illegal;

  logic [3:0]          w_flags;
  logic                w_accept;
  logic                w_cond;
  logic                w_undef;

  assign take_valid  = (r_state == S_FULL);
  assign take        = r_take;
  assign take_target = r_take_target;
  assign flags_q     = r_flags;
  assign illegal_op  = r_illegal;

  assign br_ready = !take_valid || take_ack;
  assign w_accept = br_valid && br_ready;

  // Same-cycle flag write is forwarded so a branch right after its ALU op sees fresh flags.
  assign w_flags = flag_we ? {ovf_in, sign_in, zero_in, carry_in} : r_flags;

  always_comb begin
    w_cond  = 1'b0;
    w_undef = 1'b0;
    case (br_op)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = rs_neg;
      4'd2:    w_cond = rs_zero;
      4'd3:    w_cond = !rs_zero;
      4'd4:    w_cond = w_flags[0];
      4'd5:    w_cond = !w_flags[0];
      4'd6:    w_cond = w_flags[2];
      4'd7:    w_cond = !w_flags[2];
      4'd8:    w_cond = w_flags[3];
      4'd9:    w_cond = !w_flags[3];
      default: w_undef = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_EMPTY;
      r_flags       <= 4'd0;
      r_take        <= 1'b0;
      r_take_target <= '0;
      r_illegal     <= 1'b0;
    end else begin
      if (flag_we) begin
        r_flags <= {ovf_in, sign_in, zero_in, carry_in};
      end
      if (w_accept && w_undef) begin
        r_illegal <= 1'b1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_take        <= w_cond;
            r_take_target <= br_target;
            r_state       <= S_FULL;
          end
        end
        S_FULL: begin
          if (take_ack) begin
            if (w_accept) begin
              r_take        <= w_cond;
              r_take_target <= br_target;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_branch_cond_unit: directed vectors with queued expectations.        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we, carry_in, zero_in, sign_in, ovf_in;
  logic        br_valid, br_ready;
  logic [3:0]  br_op;
  logic [31:0] br_target;
  logic        rs_zero, rs_neg;
  logic        take_valid, take;
  logic [31:0] take_target;
  logic        take_ack;
  logic [3:0]  flags_q;
  logic        illegal_op;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] sb[$];   // {take, target}

  branch_cond_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in), .ovf_in(ovf_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .br_target(br_target),
    .rs_zero(rs_zero), .rs_neg(rs_neg),
    .take_valid(take_valid), .take(take), .take_target(take_target),
    .take_ack(take_ack), .flags_q(flags_q), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a decision is consumed on the edge where take_valid && take_ack.
  always @(negedge clk) begin
    if (rst_n && take_valid && take_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_decision", {32'd0, take_target}, 64'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("take", {63'd0, take}, {63'd0, e[32]});
        chk("take_target", {32'd0, take_target}, {32'd0, e[31:0]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the flag write edge.
  task automatic setflags(input logic [3:0] fl);
    flag_we = 1'b1;
    {ovf_in, sign_in, zero_in, carry_in} = fl;
    @(posedge clk); #1;
    flag_we = 1'b0;
    chk("flags_q", {60'd0, flags_q}, {60'd0, fl});
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] tgt, input logic rz,
                       input logic rn, input logic exp_take, input logic fwe,
                       input logic [3:0] fl);
    int waited;
    br_valid  = 1'b1;
    br_op     = op;
    br_target = tgt;
    rs_zero   = rz;
    rs_neg    = rn;
    flag_we   = fwe;
    {ovf_in, sign_in, zero_in, carry_in} = fl;
    waited = 0;
    @(negedge clk);
    while (!br_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!br_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      br_valid = 1'b0;
      flag_we  = 1'b0;
      return;
    end
    sb.push_back({exp_take, tgt});
    @(posedge clk); #1;
    br_valid = 1'b0;
    flag_we  = 1'b0;
    chk("latency_valid", {63'd0, take_valid}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; take_ack = 1'b1;
    flag_we = 0; carry_in = 0; zero_in = 0; sign_in = 0; ovf_in = 0;
    br_valid = 0; br_op = 0; br_target = 0; rs_zero = 0; rs_neg = 0;
    #3;
    chk("rst_take_valid", {63'd0, take_valid}, 64'd0);
    chk("rst_flags", {60'd0, flags_q}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_op}, 64'd0);
    chk("rst_br_ready", {63'd0, br_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Flag write then BCY
    setflags(4'b0001);
    issue(4'd4, 32'h40, 0, 0, 1'b1, 0, 4'b0000);
    chk("bcy_take_now", {63'd0, take}, 64'd1);
    chk("bcy_target_now", {32'd0, take_target}, 64'h40);

    // Forwarding
    setflags(4'b0000);
    issue(4'd5, 32'h80, 0, 0, 1'b0, 1, 4'b0001);
    chk("fwd_flags", {60'd0, flags_q}, 64'b0001);
    issue(4'd4, 32'h84, 0, 0, 1'b0, 1, 4'b0000);

    // Register-operand branches back-to-back
    issue(4'd1, 32'h100, 0, 1, 1'b1, 0, 4'b0000);
    issue(4'd3, 32'h104, 1, 0, 1'b0, 0, 4'b0000);
    issue(4'd2, 32'h108, 1, 0, 1'b1, 0, 4'b0000);
    issue(4'd0, 32'h10C, 0, 0, 1'b1, 0, 4'b0000);
    issue(4'd1, 32'h110, 0, 0, 1'b0, 0, 4'b0000);

    // Flag branches with {V,S,Z,C} = 1010
    setflags(4'b1010);
    issue(4'd6, 32'h120, 0, 0, 1'b0, 0, 4'b0000);
    issue(4'd7, 32'h124, 0, 0, 1'b1, 0, 4'b0000);
    issue(4'd8, 32'h128, 0, 0, 1'b1, 0, 4'b0000);
    issue(4'd9, 32'h12C, 0, 0, 1'b0, 0, 4'b0000);
    issue(4'd5, 32'h130, 0, 0, 1'b1, 0, 4'b0000);
    issue(4'd4, 32'h134, 0, 0, 1'b0, 0, 4'b0000);
    chk("no_illegal_yet", {63'd0, illegal_op}, 64'd0);

    // Stall: hold a decision for 3 cycles while another branch waits
    issue(4'd0, 32'h200, 0, 0, 1'b1, 0, 4'b0000);
    take_ack = 1'b0;
    br_valid = 1'b1; br_op = 4'd2; br_target = 32'h300; rs_zero = 1'b0; rs_neg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {63'd0, br_ready}, 64'd0);
      chk("stall_take", {63'd0, take}, 64'd1);
      chk("stall_target", {32'd0, take_target}, 64'h200);
    end
    @(posedge clk); #1;
    take_ack = 1'b1;
    @(negedge clk);
    chk("unstall_ready", {63'd0, br_ready}, 64'd1);
    sb.push_back({1'b0, 32'h300});
    @(posedge clk); #1;
    br_valid = 1'b0;
    chk("reload_target", {32'd0, take_target}, 64'h300);
    chk("reload_take", {63'd0, take}, 64'd0);

    // Illegal op is sticky
    issue(4'd12, 32'h400, 0, 0, 1'b0, 0, 4'b0000);
    chk("illegal_set", {63'd0, illegal_op}, 64'd1);
    issue(4'd0, 32'h404, 0, 0, 1'b1, 0, 4'b0000);
    issue(4'd3, 32'h408, 0, 0, 1'b1, 0, 4'b0000);
    chk("illegal_sticky", {63'd0, illegal_op}, 64'd1);

    // Async reset while stalled with a pending decision
    issue(4'd0, 32'h500, 0, 0, 1'b1, 0, 4'b0000);
    take_ack = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_take_valid", {63'd0, take_valid}, 64'd0);
    chk("arst_take", {63'd0, take}, 64'd0);
    chk("arst_target", {32'd0, take_target}, 64'd0);
    chk("arst_flags", {60'd0, flags_q}, 64'd0);
    chk("arst_illegal", {63'd0, illegal_op}, 64'd0);
    chk("arst_br_ready", {63'd0, br_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1; take_ack = 1'b1;
    @(posedge clk); #1;
    issue(4'd1, 32'h600, 0, 1, 1'b1, 0, 4'b0000);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", {32'd0, sb.size()}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_cond_unit.md
# branch_cond_unit

Holds the processor's ALU status flags (carry, zero, sign, overflow), evaluates the condition of each branch instruction against those flags or the register operand status, and registers a one-bit taken decision plus target. It sits directly upstream of the 1-bit next-PC 2:1 select: `take` drives that mux's select, choosing the branch target over the sequential PC. A one-deep output buffer with a valid/ack handshake lets fetch stall without losing a decision.

## Interface
- ADDR_W, 32, width of branch target address
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flag_we  in  1  ALU instruction updates flags this cycle
- carry_in, zero_in, sign_in, ovf_in  in  1 each  ALU flag results
- br_valid  in  1  branch instruction presented
- br_ready  out  1  unit can accept a branch this cycle
- br_op  in  4  condition code (see Operation)
- br_target  in  ADDR_W  branch target address
- rs_zero  in  1  branch register operand == 0
- rs_neg  in  1  branch register operand bit 31
- take_valid  out  1  registered decision available
- take  out  1  1 = branch taken (select for next-PC mux)
- take_target  out  ADDR_W  registered target
- take_ack  in  1  downstream consumed the decision
- flags_q  out  4  {ovf, sign, zero, carry} currently held
- illegal_op  out  1  sticky: an undefined br_op was accepted

## Operation
- Flag register: on clk edge with flag_we=1, flags_q <= {ovf_in, sign_in, zero_in, carry_in}; otherwise holds.
- Condition codes: 0 BR always; 1 BLTZ rs_neg; 2 BZ rs_zero; 3 BNZ !rs_zero; 4 BCY C; 5 BNCY !C; 6 BS S; 7 BNS !S; 8 BV V; 9 BNV !V; 10–15 undefined → take=0, illegal_op set.
- Flag forwarding: when flag_we and an accepted branch occur in the same cycle, conditions 4–9 use the incoming *_in values, not flags_q.
- Accept: branch accepted when br_valid && br_ready. br_ready = !take_valid || take_ack.
- FSM, two states:
  - EMPTY (take_valid=0): accept → load take/take_target, go FULL.
  - FULL (take_valid=1): take_ack && accept → reload, stay FULL; take_ack && !accept → EMPTY; !take_ack → hold all outputs stable.
- take_target loaded with br_target regardless of taken value.
- illegal_op clears only on reset.

## Timing
- Reset (async assert, sync-released by upstream): flags_q=0, take_valid=0, take=0, take_target=0, illegal_op=0, state EMPTY; br_ready=1 immediately.
- Latency: decision visible one cycle after acceptance edge.
- Throughput: one branch per cycle with continuous take_ack.
- Flag write latency: flags_q updates on the edge following flag_we; branch in that same cycle sees forwarded value.
- br_ready is combinational from take_valid and take_ack; no combinational path from br_valid to any output.
- Reset mid-FULL: pending decision discarded, take_valid=0 asynchronously.
- br_valid while !br_ready: ignored; upstream must hold.

## Test plan
- Reset with take_valid=1 mid-stall → take_valid, take, flags_q, illegal_op all 0 without clock edge; br_ready=1.
- flag_we=1 with carry_in=1, next cycle br_op=4 br_target=0x40 → take_valid=1, take=1, take_target=0x40 one cycle later.
- Same-cycle flag_we (zero_in=0, carry_in=1, flags_q.C=0) and br_op=5 → take=0 (forwarded C=1 used).
- br_op=1 rs_neg=1, then br_op=3 rs_zero=1 back-to-back, take_ack=1 → take=1 then take=0 on consecutive cycles.
- take_ack=0 for 3 cycles with br_valid=1 → br_ready=0, take/take_target unchanged; take_ack=1 → new decision loaded next edge.
- br_op=12 accepted → take=0, illegal_op=1, remains 1 after further legal branches until reset.
